// File: rtl/spikey_spi_pkg.sv
// Shared types and helpers for the Spikey SPI master.
//   spi_state_e    : frame sequencer states
//   SPI_MODEx      : {cpol, cpha} mode encoding
//   edge_cnt_w()   : width of the SCLK edge counter for a given frame width
//   mode_cpol/cpha : decode a mode pair back to its fields
package spikey_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // A frame has 2*data_w SCLK edges; the counter must hold that value.
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

    function automatic logic mode_cpha(input logic [1:0] m);
        return (m == SPI_MODE1) || (m == SPI_MODE3);
    endfunction

    function automatic logic mode_cpol(input logic [1:0] m);
        return (m == SPI_MODE2) || (m == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spikey_spi_tick.sv
// Programmable FCLK divider.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear; holds the count at 0 and suppresses tick
//   load     : captures div as the terminal count
//   div      : terminal count (period = div+1 cycles)
//   tick     : one-cycle pulse in the cycle the count reaches div
module spikey_spi_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    assign tick = !clr && (cnt == div_q);

    // Wrap compares against the terminal count, so div = all-ones never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (load)
                div_q <= div;
            if (clr || cnt == div_q)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spikey_spi_master.sv
// SPI master engine: programmable SCLK divider, CPOL/CPHA modes, bit order.
//   FCLK, RST          : clock, asynchronous active-high reset
//   cfg_*              : divider, mode and bit order; captured at accept
//   tx_valid/ready/data: one word per frame
//   rx_valid/rx_data   : received word, rx_valid pulses for one cycle
//   sclk, mosi, miso, cs_n : SPI pads
//   busy               : sequencer not idle
//   sclk_lead/trail    : one-cycle strobes aligned with the new sclk level
module spikey_spi_master
    import spikey_spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              FCLK,
    input  logic              RST,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              busy,
    output logic              sclk_lead,
    output logic              sclk_trail
);

    localparam int EW = edge_cnt_w(DATA_W);
    localparam int IW = $clog2(DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    spi_state_e        state;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_sh;
    logic [EW-1:0]     edge_cnt;
    logic [EW-1:0]     edge_nxt;
    logic [EW-1:0]     shift_i;
    logic [IW-1:0]     sh_pos;
    logic [IW-1:0]     sm_pos;
    logic [1:0]        mode_q;
    logic              lsb_q;
    logic              cpha_q;
    logic              cpol_q;
    logic              tick;
    logic              accept;

    assign tx_ready = (state == ST_IDLE);
    assign busy     = !tx_ready;
    assign accept   = tx_ready && tx_valid;
    assign cpha_q   = mode_cpha(mode_q);
    assign cpol_q   = mode_cpol(mode_q);

    // The divider idles cleared; every later state change happens on a tick,
    // where the count wraps to 0, so each state starts a full period.
    spikey_spi_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (FCLK),
        .rst  (RST),
        .clr  (state == ST_IDLE),
        .load (accept),
        .div  (cfg_div),
        .tick (tick)
    );

    // Edge k (1-based) is odd for leading edges. The bit driven on edge k is
    // index k>>1; the bit sampled on edge k is index (k-1)>>1 = edge_cnt>>1.
    assign edge_nxt = edge_cnt + 1'b1;
    assign shift_i  = edge_nxt >> 1;
    assign sh_pos   = lsb_q ? shift_i[IW-1:0] : IW'(DATA_W - 1) - shift_i[IW-1:0];
    assign sm_pos   = lsb_q ? edge_cnt[IW:1]  : IW'(DATA_W - 1) - edge_cnt[IW:1];

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            sclk_lead  <= 1'b0;
            sclk_trail <= 1'b0;
            tx_q       <= '0;
            rx_sh      <= '0;
            edge_cnt   <= '0;
            mode_q     <= SPI_MODE0;
            lsb_q      <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            sclk_lead  <= 1'b0;
            sclk_trail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk <= cfg_cpol;
                    if (accept) begin
                        tx_q     <= tx_data;
                        mode_q   <= {cfg_cpol, cfg_cpha};
                        lsb_q    <= cfg_lsb_first;
                        edge_cnt <= '0;
                        cs_n     <= 1'b0;
                        state    <= ST_SETUP;
                        // CPHA=0 slaves sample on the first edge, so bit 0 must be out now.
                        if (!cfg_cpha)
                            mosi <= cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    end
                end
                // The SETUP tick produces edge 1; XFER ticks produce edges 2..2N.
                ST_SETUP, ST_XFER: begin
                    if (tick) begin
                        sclk       <= ~sclk;
                        edge_cnt   <= edge_nxt;
                        sclk_lead  <= edge_nxt[0];
                        sclk_trail <= ~edge_nxt[0];
                        if (edge_nxt[0] != cpha_q)
                            rx_sh[sm_pos] <= miso;
                        else if (shift_i < EW'(DATA_W))
                            mosi <= tx_q[sh_pos];
                        if (state == ST_SETUP)
                            state <= ST_XFER;
                        else if (edge_nxt == LAST_EDGE)
                            state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    sclk <= cpol_q;
                    if (tick) begin
                        cs_n     <= 1'b1;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    sclk <= cpol_q;
                    if (tick)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
